// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, bit-period divisor helper and
// receiver FSM state encoding. Used by uart_rx and uart_tx.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Clocks per bit for a baud code; unused codes fall back to 115200.
  function automatic logic [15:0] bps_cnt(input int unsigned clk_freq,
                                          input logic [2:0]  code);
    int unsigned baud;
    case (code)
      BAUD_9600:  baud = 9600;
      BAUD_19200: baud = 19200;
      BAUD_38400: baud = 38400;
      BAUD_57600: baud = 57600;
      default:    baud = 115200;
    endcase
    return 16'(clk_freq / baud);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge detect.
// All flops reset high so an idle line never produces a spurious edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic rx_s_d;

  // Synchronize rx and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      meta   <= rx;
      rx_s   <= meta;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, run-time baud select. Each bit is a 3-sample
// majority vote around mid-bit; the decision is taken on the third sample.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_set,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  rx_state_t   state;
  logic        rx_s;
  logic        fall;
  logic [15:0] bps_q;
  logic [15:0] div_cnt;
  logic [15:0] mid;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        s0;
  logic        s1;
  logic        vote;
  logic        at_vote;
  logic        div_wrap;
  logic        par_ok;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign mid      = (bps_q >> 1) - 16'd1;
  assign at_vote  = (div_cnt == mid + 16'd1);
  assign div_wrap = (div_cnt == bps_q - 16'd1);
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign busy     = (state != IDLE);

  // First two majority samples; the third is rx_s itself at the vote point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (div_cnt == mid - 16'd1) s0 <= rx_s;
      if (div_cnt == mid)         s1 <= rx_s;
    end
  end

  // Bit-period divider; the divisor is frozen at the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 16'd0;
      bps_q   <= 16'd0;
    end else if (state == IDLE) begin
      div_cnt <= 16'd0;
      if (fall) bps_q <= bps_cnt(CLK_FREQ, baud_set);
    end else if (div_wrap) begin
      div_cnt <= 16'd0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Frame FSM and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_ok     <= 1'b1;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            bit_cnt <= 3'd0;
          end
        end
        START: begin
          if (at_vote) state <= vote ? IDLE : DATA;
        end
        DATA: begin
          if (at_vote) begin
            shreg   <= {vote, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_vote) begin
            par_ok     <= (vote == ^shreg);
            parity_err <= (vote != ^shreg);
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start
          if (at_vote) begin
            state <= IDLE;
            if (!vote) begin
              frame_err <= 1'b1;
            end else if (par_ok) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A frame-level model predicts, for every
// frame sent, which strobe must appear, when (in bit periods from the start
// edge) and what rx_data must then hold; a compare process checks the DUT
// against that prediction on every cycle.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 100000000;
  localparam int BPS4 = 868;  // 100 MHz / 115200

  logic       clk;
  logic       rst_n;
  logic [2:0] baud_set;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct {
    int         kind;  // 0 done, 1 frame error, 2 parity error
    logic [7:0] data;
    longint     when;
  } ev_t;

  ev_t        exp_q[$];
  longint     cyc;
  longint     last_done_cyc;
  logic [7:0] model_data;
  int         checks;
  int         errors;
  int         n_done;
  int         n_ferr;
  int         n_perr;
`ifdef UART_RX_PARITY_EN
  logic       par_flip;
`endif

  uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_set  (baud_set),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Predict the outcome of a frame, then drive it bit by bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bps,
                            input int low_after, output longint t0);
    ev_t ev;
    int  nb;
    t0 = cyc;
    ev.data = d;
`ifdef UART_RX_PARITY_EN
    logic par;
    par = (^d) ^ par_flip;
    nb  = 10;
    if (par != ^d) begin
      ev.kind = 2;
      ev.when = t0 + 9 * bps + bps / 2;
      exp_q.push_back(ev);
    end
    if (!stop) begin
      ev.kind = 1;
      ev.when = t0 + nb * bps + bps / 2;
      exp_q.push_back(ev);
    end else if (par == ^d) begin
      ev.kind = 0;
      ev.when = t0 + nb * bps + bps / 2;
      exp_q.push_back(ev);
    end
`else
    nb = 9;
    ev.kind = stop ? 0 : 1;
    ev.when = t0 + nb * bps + bps / 2;
    exp_q.push_back(ev);
`endif
    rx = 1'b0;
    tick(bps);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(bps);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    tick(bps);
`endif
    rx = stop;
    tick(bps);
    tick(low_after);
    rx = 1'b1;
  endtask

  // Compare process: strobes against the predicted events, rx_data every cycle
  always @(negedge clk) begin
    int     k;
    ev_t    ev;
    logic [2:0] req;
    if (!rst_n) begin
      model_data = 8'h00;
      exp_q.delete();
      chk("reset_outputs", {rx_data, rx_done, frame_err, parity_err, busy}, 12'h000);
    end else begin
      k = int'(rx_done) + int'(frame_err) + int'(parity_err);
      chk("strobe_exclusive", (k <= 1), 1);
      if (k != 0) begin
        if (rx_done) begin n_done++; last_done_cyc = cyc; end
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {rx_done, frame_err, parity_err}, 3'b000);
        end else begin
          ev  = exp_q.pop_front();
          req = (ev.kind == 0) ? 3'b100 : (ev.kind == 1) ? 3'b010 : 3'b001;
          chk("strobe_kind", {rx_done, frame_err, parity_err}, req);
          chk("strobe_time_ok", (cyc >= ev.when - 10) && (cyc <= ev.when + 10), 1);
          if (ev.kind == 0 && rx_done) model_data = ev.data;
        end
      end
      chk("rx_data", rx_data, model_data);
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    longint tb2;
    int     bcnt;
    logic   seen;
    checks = 0; errors = 0; n_done = 0; n_ferr = 0; n_perr = 0;
    cyc = 0; last_done_cyc = 0; model_data = 8'h00;
    rx = 1'b1; baud_set = 3'd4; rst_n = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    #2 rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(5);

    // Single 0x55 at 115200
    send_frame(8'h55, 1'b1, BPS4, 0, t0);
    tick(20);
    chk("t1_data", rx_data, 8'h55);
    chk("t1_done_count", n_done, 1);
    chk("t1_ferr_count", n_ferr, 0);
`ifdef UART_RX_PARITY_EN
    chk("t1_latency_ok", (last_done_cyc - t0 >= 9104) && (last_done_cyc - t0 <= 9124), 1);
`else
    chk("t1_latency_ok", (last_done_cyc - t0 >= 8240) && (last_done_cyc - t0 <= 8260), 1);
`endif

    // Back-to-back 0xA5, 0x3C with no idle gap
    send_frame(8'hA5, 1'b1, BPS4, 0, t0);
    send_frame(8'h3C, 1'b1, BPS4, 0, tb2);
    tick(20);
    chk("t2_data", rx_data, 8'h3C);
    chk("t2_done_count", n_done, 3);
    chk("t2_ferr_count", n_ferr, 0);

    // 200 ns low glitch: busy must rise then drop within 435 clocks, no strobe
    rx = 1'b0;
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (i == 20) rx = 1'b1;
      tick(1);
      if (busy) begin bcnt++; seen = 1'b1; end
      else if (seen) break;
    end
    chk("t3_busy_seen", seen, 1);
    chk("t3_busy_len_ok", (bcnt <= 435), 1);
    chk("t3_busy_end", busy, 0);
    chk("t3_done_count", n_done, 3);

    // 0xFF with stop low, line then held low (break); baud_set changed mid-frame
    fork
      send_frame(8'hFF, 1'b0, BPS4, 3 * BPS4, t0);
      begin tick(100); baud_set = 3'd0; end
    join
    tick(50);
    chk("t4_ferr_count", n_ferr, 1);
    chk("t4_done_count", n_done, 3);
    chk("t4_data_kept", rx_data, 8'h3C);
    chk("t4_busy", busy, 0);

    // Reset during bit 4 of 0x81, then 0x7E at code 7 (maps to 115200)
    baud_set = 3'd4;
    rx = 1'b0; tick(BPS4);
    rx = 1'b1; tick(BPS4);
    rx = 1'b0; tick(3 * BPS4);
    tick(BPS4 / 2);
    rst_n = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2);
    chk("t5_busy_in_reset", busy, 0);
    rst_n = 1'b1;
    tick(10);
    chk("t5_data_after_reset", rx_data, 8'h00);
    chk("t5_no_strobe", n_done, 3);
    baud_set = 3'd7;
    send_frame(8'h7E, 1'b1, BPS4, 0, t0);
    tick(20);
    chk("t5_data", rx_data, 8'h7E);
    chk("t5_done_count", n_done, 4);

`ifdef UART_RX_PARITY_EN
    // 0x03 with wrong (1) then correct (0) parity bit
    baud_set = 3'd4;
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1, BPS4, 0, t0);
    tick(20);
    chk("t6_perr_count", n_perr, 1);
    chk("t6_done_count", n_done, 4);
    chk("t6_data_kept", rx_data, 8'h7E);
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1, BPS4, 0, t0);
    tick(20);
    chk("t7_data", rx_data, 8'h03);
    chk("t7_done_count", n_done, 5);
    chk("t7_perr_count", n_perr, 1);
`else
    chk("perr_never", n_perr, 0);
`endif

    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
